// File: rtl/attack_eval_pkg.sv
// Shared piece encodings, colour-field layout and scan FSM states for attack_eval.
package attack_eval_pkg;

  localparam int unsigned PIECE_W    = 4;
  localparam int unsigned SIDE_W     = 1;
  localparam int unsigned COLOUR_LSB = PIECE_W - SIDE_W;

  localparam logic [SIDE_W-1:0]     SIDE_WHITE = '0;
  localparam logic [SIDE_W-1:0]     SIDE_BLACK = '1;
  localparam logic [COLOUR_LSB-1:0] KIND_KING  = 3'd6;

  // Piece code is {colour, kind}; kind 0 is an empty square.
  localparam logic [PIECE_W-1:0] EMPTY_POSN = '0;
  localparam logic [PIECE_W-1:0] WHITE_KING = {SIDE_WHITE, KIND_KING};
  localparam logic [PIECE_W-1:0] BLACK_KING = {SIDE_BLACK, KIND_KING};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/attack_eval_rank_reduce.sv
// Combinational reduction of one rank: attack popcounts and king-in-check bits.
module rank_reduce
  import attack_eval_pkg::*;
#(
  parameter int unsigned PIECE_WIDTH = PIECE_W,
  parameter int unsigned SIDE_WIDTH  = SIDE_W
) (
  input  logic [8*PIECE_WIDTH-1:0] squares,
  input  logic [7:0]               white_bits,
  input  logic [7:0]               black_bits,
  output logic [3:0]               white_cnt,
  output logic [3:0]               black_cnt,
  output logic                     white_chk,
  output logic                     black_chk
);

  localparam int unsigned KW = PIECE_WIDTH - SIDE_WIDTH;

  always_comb begin
    white_cnt = popcount8(white_bits);
    black_cnt = popcount8(black_bits);
    white_chk = 1'b0;
    black_chk = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (squares[i*PIECE_WIDTH +: KW] == KW'(KIND_KING)) begin
        if ((squares[i*PIECE_WIDTH+KW +: SIDE_WIDTH] == SIDE_WIDTH'(SIDE_WHITE)) && black_bits[i])
          white_chk = 1'b1;
        if ((squares[i*PIECE_WIDTH+KW +: SIDE_WIDTH] == SIDE_WIDTH'(SIDE_BLACK)) && white_bits[i])
          black_chk = 1'b1;
      end
    end
  end

endmodule

// File: rtl/attack_eval.sv
// Reduces white/black attack maps over 8 cycles (one rank per cycle) into
// control counts, a signed control difference and king-in-check flags.
module attack_eval
  import attack_eval_pkg::*;
#(
  parameter int unsigned PIECE_WIDTH = 4,
  parameter int unsigned SIDE_WIDTH  = 1,
  parameter int unsigned BOARD_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic                   board_valid,
  input  logic [63:0]            white_is_attacking,
  input  logic [63:0]            black_is_attacking,
  input  logic                   is_attacking_done,
  output logic [6:0]             white_control,
  output logic [6:0]             black_control,
  output logic [7:0]             control_diff,
  output logic                   white_in_check,
  output logic                   black_in_check,
  output logic                   eval_valid,
  output logic                   busy
);

  localparam int unsigned RANK_W = 8 * PIECE_WIDTH;

  state_e                 state_q, state_d;
  logic [2:0]             rank_q, rank_d;
  logic                   done_q, done_d;
  logic [BOARD_WIDTH-1:0] board_pend_q, board_pend_d;
  logic [BOARD_WIDTH-1:0] board_work_q, board_work_d;
  logic [63:0]            wmap_q, wmap_d;
  logic [63:0]            bmap_q, bmap_d;
  logic [6:0]             wacc_q, wacc_d;
  logic [6:0]             bacc_q, bacc_d;
  logic                   wchk_q, wchk_d;
  logic                   bchk_q, bchk_d;
  logic [6:0]             white_control_q, white_control_d;
  logic [6:0]             black_control_q, black_control_d;
  logic [7:0]             control_diff_q, control_diff_d;
  logic                   white_in_check_q, white_in_check_d;
  logic                   black_in_check_q, black_in_check_d;
  logic                   eval_valid_q, eval_valid_d;

  logic [RANK_W-1:0] rank_sq;
  logic [7:0]        rank_w, rank_b;
  logic [3:0]        rank_wcnt, rank_bcnt;
  logic              rank_wchk, rank_bchk;
  logic              done_rise;

  always_comb begin
    rank_sq = '0;
    rank_w  = '0;
    rank_b  = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      if (rank_q == 3'(r)) begin
        rank_sq = board_work_q[r*RANK_W +: RANK_W];
        rank_w  = wmap_q[r*8 +: 8];
        rank_b  = bmap_q[r*8 +: 8];
      end
    end
  end

  rank_reduce #(
    .PIECE_WIDTH (PIECE_WIDTH),
    .SIDE_WIDTH  (SIDE_WIDTH)
  ) u_rank_reduce (
    .squares    (rank_sq),
    .white_bits (rank_w),
    .black_bits (rank_b),
    .white_cnt  (rank_wcnt),
    .black_cnt  (rank_bcnt),
    .white_chk  (rank_wchk),
    .black_chk  (rank_bchk)
  );

  assign done_rise = is_attacking_done & ~done_q;

  always_comb begin
    state_d          = state_q;
    rank_d           = rank_q;
    done_d           = is_attacking_done;
    board_pend_d     = board_valid ? board : board_pend_q;
    board_work_d     = board_work_q;
    wmap_d           = wmap_q;
    bmap_d           = bmap_q;
    wacc_d           = wacc_q;
    bacc_d           = bacc_q;
    wchk_d           = wchk_q;
    bchk_d           = bchk_q;
    white_control_d  = white_control_q;
    black_control_d  = black_control_q;
    control_diff_d   = control_diff_q;
    white_in_check_d = white_in_check_q;
    black_in_check_d = black_in_check_q;
    eval_valid_d     = 1'b0;

    // A new rising edge restarts from any state and suppresses a pending result.
    if (done_rise) begin
      wmap_d       = white_is_attacking;
      bmap_d       = black_is_attacking;
      board_work_d = board_pend_q;
      wacc_d       = '0;
      bacc_d       = '0;
      wchk_d       = 1'b0;
      bchk_d       = 1'b0;
      rank_d       = '0;
      state_d      = SCAN;
    end else begin
      case (state_q)
        IDLE: ;
        SCAN: begin
          wacc_d = wacc_q + {3'b000, rank_wcnt};
          bacc_d = bacc_q + {3'b000, rank_bcnt};
          wchk_d = wchk_q | rank_wchk;
          bchk_d = bchk_q | rank_bchk;
          rank_d = rank_q + 3'd1;
          if (rank_q == 3'd7) state_d = DONE;
        end
        DONE: begin
          white_control_d  = wacc_q;
          black_control_d  = bacc_q;
          control_diff_d   = {1'b0, wacc_q} - {1'b0, bacc_q};
          white_in_check_d = wchk_q;
          black_in_check_d = bchk_q;
          eval_valid_d     = 1'b1;
          state_d          = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      rank_q           <= '0;
      done_q           <= 1'b0;
      board_pend_q     <= '0;
      board_work_q     <= '0;
      wmap_q           <= '0;
      bmap_q           <= '0;
      wacc_q           <= '0;
      bacc_q           <= '0;
      wchk_q           <= 1'b0;
      bchk_q           <= 1'b0;
      white_control_q  <= '0;
      black_control_q  <= '0;
      control_diff_q   <= '0;
      white_in_check_q <= 1'b0;
      black_in_check_q <= 1'b0;
      eval_valid_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      rank_q           <= rank_d;
      done_q           <= done_d;
      board_pend_q     <= board_pend_d;
      board_work_q     <= board_work_d;
      wmap_q           <= wmap_d;
      bmap_q           <= bmap_d;
      wacc_q           <= wacc_d;
      bacc_q           <= bacc_d;
      wchk_q           <= wchk_d;
      bchk_q           <= bchk_d;
      white_control_q  <= white_control_d;
      black_control_q  <= black_control_d;
      control_diff_q   <= control_diff_d;
      white_in_check_q <= white_in_check_d;
      black_in_check_q <= black_in_check_d;
      eval_valid_q     <= eval_valid_d;
    end
  end

  assign white_control  = white_control_q;
  assign black_control  = black_control_q;
  assign control_diff   = control_diff_q;
  assign white_in_check = white_in_check_q;
  assign black_in_check = black_in_check_q;
  assign eval_valid     = eval_valid_q;
  assign busy           = (state_q == SCAN);

endmodule

// File: tb/tb_attack_eval.sv
// Directed bench for attack_eval: expected results queued at each start, checked on eval_valid.
module tb_attack_eval;
  import attack_eval_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board;
  logic         board_valid;
  logic [63:0]  white_is_attacking;
  logic [63:0]  black_is_attacking;
  logic         is_attacking_done;
  logic [6:0]   white_control;
  logic [6:0]   black_control;
  logic [7:0]   control_diff;
  logic         white_in_check;
  logic         black_in_check;
  logic         eval_valid;
  logic         busy;

  attack_eval #(
    .PIECE_WIDTH (4),
    .SIDE_WIDTH  (1),
    .BOARD_WIDTH (256)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .board              (board),
    .board_valid        (board_valid),
    .white_is_attacking (white_is_attacking),
    .black_is_attacking (black_is_attacking),
    .is_attacking_done  (is_attacking_done),
    .white_control      (white_control),
    .black_control      (black_control),
    .control_diff       (control_diff),
    .white_in_check     (white_in_check),
    .black_in_check     (black_in_check),
    .eval_valid         (eval_valid),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] w;
    logic [6:0] b;
    logic [7:0] d;
    logic       wic;
    logic       bic;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  exp_t         sb[$];
  logic [255:0] pend_model;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [255:0] brd, input logic [63:0] wm,
                                      input logic [63:0] bm);
    exp_t e;
    int   wn, bn;
    wn    = $countones(wm);
    bn    = $countones(bm);
    e.cyc = 0;
    e.w   = 7'(wn);
    e.b   = 7'(bn);
    e.d   = 8'(wn - bn);
    e.wic = 1'b0;
    e.bic = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (brd[n*4 +: 4] == WHITE_KING && bm[n]) e.wic = 1'b1;
      if (brd[n*4 +: 4] == BLACK_KING && wm[n]) e.bic = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [255:0] start_board();
    logic [255:0] b;
    int           back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i*4 +: 4]      = 4'(back[i]);
      b[(8+i)*4 +: 4]  = 4'h1;
      b[(48+i)*4 +: 4] = 4'h9;
      b[(56+i)*4 +: 4] = 4'(8 + back[i]);
    end
    return b;
  endfunction

  function automatic logic [255:0] king_board(input int wk, input int bk);
    logic [255:0] b;
    b = '0;
    for (int n = 0; n < 64; n++) b[n*4 +: 4] = EMPTY_POSN;
    if (wk >= 0) b[wk*4 +: 4] = WHITE_KING;
    if (bk >= 0) b[bk*4 +: 4] = BLACK_KING;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!reset && eval_valid) begin
      exp_t e;
      chk("eval_expected", 32'(sb.size() != 0), 32'd1);
      chk("busy_at_eval", 32'(busy), 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("eval_cycle", 32'(cyc), 32'(e.cyc));
        chk("white_control", 32'(white_control), 32'(e.w));
        chk("black_control", 32'(black_control), 32'(e.b));
        chk("control_diff", 32'(control_diff), 32'(e.d));
        chk("white_in_check", 32'(white_in_check), 32'(e.wic));
        chk("black_in_check", 32'(black_in_check), 32'(e.bic));
      end
    end
  end

  task automatic load_board(input logic [255:0] nb);
    @(negedge clk);
    board       = nb;
    board_valid = 1'b1;
    pend_model  = nb;
    @(negedge clk);
    board_valid = 1'b0;
  endtask

  task automatic start(input logic [63:0] wm, input logic [63:0] bm, input bit expect_it,
                       input bit with_board, input logic [255:0] nb);
    exp_t e;
    @(negedge clk);
    white_is_attacking = wm;
    black_is_attacking = bm;
    is_attacking_done  = 1'b1;
    if (expect_it) begin
      e     = expect_for(pend_model, wm, bm);
      e.cyc = cyc + 10;
      sb.push_back(e);
    end
    if (with_board) begin
      board       = nb;
      board_valid = 1'b1;
      pend_model  = nb;
    end
    @(negedge clk);
    is_attacking_done = 1'b0;
    board_valid       = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset              = 1'b1;
    board              = '0;
    board_valid        = 1'b0;
    white_is_attacking = '0;
    black_is_attacking = '0;
    is_attacking_done  = 1'b0;
    pend_model         = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_white_control", 32'(white_control), 32'd0);
    chk("rst_black_control", 32'(black_control), 32'd0);
    chk("rst_control_diff", 32'(control_diff), 32'd0);
    chk("rst_checks", 32'({white_in_check, black_in_check}), 32'd0);
    chk("rst_eval_valid", 32'(eval_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Start position, pawn-front maps.
    load_board(start_board());
    start(64'h0000_0000_00FF_FF00, 64'h00FF_FF00_0000_0000, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    #1 chk("busy_scan", 32'(busy), 32'd1);
    drain(20);
    chk("busy_idle", 32'(busy), 32'd0);

    // White king on e1 attacked by black.
    load_board(king_board(4, 60));
    start(64'h0, 64'h1 << 4, 1'b1, 1'b0, '0);
    drain(20);

    // Full-board maps both ways.
    start('1, '0, 1'b1, 1'b0, '0);
    drain(20);
    start('0, '1, 1'b1, 1'b0, '0);
    drain(20);

    // Restart mid-scan: only the second start produces a result.
    load_board(start_board());
    start(64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    start(64'h0000_0000_0F0F_0000, 64'h1000_0000_0000_0010, 1'b1, 1'b0, '0);
    drain(25);

    // New board during a scan applies only to the next start.
    load_board(king_board(4, 60));
    start(64'h0, 64'h1 << 4, 1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);
    load_board(king_board(0, 63));
    drain(20);
    start(64'h0, 64'h1 << 4, 1'b1, 1'b0, '0);
    drain(20);

    // board_valid coincident with the start: the scan keeps the previous pending board.
    start(64'h0, 64'h1 << 4, 1'b1, 1'b1, king_board(4, 60));
    drain(20);
    start(64'h8000_0000_0000_0000, 64'h1 << 4, 1'b1, 1'b0, '0);
    drain(20);

    // Random maps over the start position.
    load_board(start_board());
    for (int k = 0; k < 3; k++) begin
      start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, '0);
      drain(20);
    end

    // Reset mid-scan: outputs clear at once and no result appears.
    start(64'h0, 64'h1 << 4, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_white_control", 32'(white_control), 32'd0);
    chk("midrst_black_control", 32'(black_control), 32'd0);
    chk("midrst_control_diff", 32'(control_diff), 32'd0);
    chk("midrst_checks", 32'({white_in_check, black_in_check}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    pend_model = '0;
    repeat (12) @(negedge clk);
    start(64'h0000_00FF_0000_0001, 64'h0000_0000_0003_0000, 1'b1, 1'b0, '0);
    drain(20);
    load_board(king_board(4, 60));
    start(64'h1000_0000_0000_0000, 64'h0000_0000_0000_0010, 1'b1, 1'b0, '0);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/attack_eval.md
Name: attack_eval

Overview:
- Consumes the attack bitmaps from the board-attack stage and reduces them over 8 cycles, one rank per cycle.
- Produces per-side square-control counts, a signed control difference and in-check flags for both kings.
- Output feeds the search/evaluation stage.
- Holds its own board snapshot so upstream may present a new board while a scan is in flight.

Parameters:
- PIECE_WIDTH, 4, bits per square encoding.
- SIDE_WIDTH, 1, bits of colour field within a piece code.
- BOARD_WIDTH, 256, total board width; must equal 64*PIECE_WIDTH. Square n is board[n*PIECE_WIDTH +: PIECE_WIDTH]; square 0 is a1 and square 63 is h8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- board  input  BOARD_WIDTH  board presented alongside board_valid
- board_valid  input  1  one-cycle strobe; board is sampled on this cycle
- white_is_attacking  input  64  squares attacked by white; bit n = square n
- black_is_attacking  input  64  squares attacked by black
- is_attacking_done  input  1  attack maps valid; level signal, the block acts on its rising edge
- white_control  output  7  number of squares white attacks, 0..64
- black_control  output  7  number of squares black attacks, 0..64
- control_diff  output  8  signed value white_control - black_control, range -64..+64
- white_in_check  output  1  white king stands on a square in black_is_attacking
- black_in_check  output  1  black king stands on a square in white_is_attacking
- eval_valid  output  1  one-cycle strobe; all result outputs are valid and held until the next strobe
- busy  output  1  high while a scan is in progress

Behaviour:
- Reset (asynchronous): all outputs are 0. The FSM returns to IDLE. The board_pend, board_work and map registers are cleared.
- Board capture: when board_valid is high, board_pend <= board. This happens in any state and does not disturb board_work.
- Start: done_rise = is_attacking_done & ~done_q, where done_q is the registered is_attacking_done.
  - On done_rise, capture both maps and copy board_pend into board_work.
  - Clear the accumulators, set rank <= 0, go to SCAN.
- States:
  - IDLE: busy=0. On done_rise, go to SCAN.
  - SCAN: busy=1. Each cycle processes rank r (squares 8r..8r+7):
    - wacc += popcount(white map bits of rank r).
    - bacc += popcount(black map bits of rank r).
    - wchk |= OR over that rank of (square == WHITE_KING & black bit).
    - bchk |= OR over that rank of (square == BLACK_KING & white bit).
    - rank increments. After r=7, go to DONE.
  - DONE:
    - Register white_control=wacc, black_control=bacc, control_diff = {1'b0,wacc} - {1'b0,bacc}.
    - Register white_in_check=wchk, black_in_check=bchk.
    - Assert eval_valid for this cycle only, busy=0, go to IDLE.
- Latency: done_rise sampled at edge E; SCAN occupies edges E+1..E+8; eval_valid is high in the cycle after edge E+9. The block accepts a new done_rise one cycle later.
- Restart: a done_rise while in SCAN or DONE aborts the current scan, recaptures maps and board, and restarts at rank 0. No eval_valid is emitted for the aborted scan.
- Simultaneous board_valid and done_rise: board_work takes the board_pend value from before that edge. The new board waits for the next done_rise.
- Width rules:
  - Accumulators are 7 bits; the maximum of 64 fits with no saturation.
  - Per-rank popcount is 4 bits.
  - control_diff is computed in 8-bit two's complement.
- Kings: a missing king yields no check. Several kings of one colour: check is the OR over all of them.
- Result outputs keep their last values between eval_valid strobes; only eval_valid itself drops.

Decomposition:
- Shared package/header holds:
  - Piece encodings EMPTY_POSN, WHITE_KING, BLACK_KING.
  - The colour-field position derived from SIDE_WIDTH.
  - The FSM state encoding constants (IDLE, SCAN, DONE).
- One sub-module, rank_reduce. It is purely combinational.
  - Inputs: 8 squares of board_work, the 8 white map bits, the 8 black map bits.
  - Outputs: the two 4-bit popcounts and the two per-rank check bits.

Test Plan:
- Start position; maps 0x0000_0000_00FF_FF00 (white) and 0x00FF_FF00_0000_0000 (black); done pulse -> eval_valid 10 cycles later; white_control=16, black_control=16, control_diff=0, both check flags 0.
- White king on e1 (sq 4), black_is_attacking = 1<<4, white map = 0 -> white_in_check=1, black_in_check=0, black_control=1, control_diff=-1 (8'hFF).
- All-ones white map, zero black map -> white_control=64, control_diff=+64; the same with colours swapped gives 8'hC0.
- Second done rise 4 cycles into a scan with new maps -> exactly one eval_valid, 10 cycles after the second rise, reflecting only the new maps.
- board_valid with a new board during SCAN -> current result uses the old board; the next done rise uses the new board.
- Assert reset at scan cycle 5 -> outputs 0 immediately and no eval_valid; a fresh done rise after release gives correct results.
